// File: rtl/tx_framereader_if.sv
// Frame reader bus: request/status handshake, symbol RAM read port and symbol stream.
interface tx_framereader_if;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned RAM_W  = 16;
   localparam int unsigned SMP_W  = 12;
   localparam int unsigned CNT_W  = 10;

   logic              framestart;
   logic              busy;
   logic              framedone;
   logic              err;
   logic [ADDR_W-1:0] symin_addr;
   logic [RAM_W-1:0]  symin;
   logic              symouten;
   logic [SMP_W-1:0]  symout_re;
   logic [SMP_W-1:0]  symout_im;
   logic [CNT_W-1:0]  symcnt;

   // Frame reader side
   modport master (
      input  framestart, symin,
      output busy, framedone, err, symin_addr, symouten, symout_re, symout_im, symcnt
   );

   // Requester / RAM / DAC side
   modport slave (
      output framestart, symin,
      input  busy, framedone, err, symin_addr, symouten, symout_re, symout_im, symcnt
   );
endinterface

// File: rtl/tx_framereader.sv
// Transmit frame reader: emits preamble, RAM payload and zero guard as a symbol stream,
// each symbol held for SYM_PER clocks, all in the DAC clock domain.
module tx_framereader #(
   parameter int unsigned SYM_PER   = 8,
   parameter int unsigned PRE_LEN   = 32,
   parameter int          PRE_AMP   = 1024,
   parameter int unsigned NSYM      = 128,
   parameter int unsigned GUARD_LEN = 16
) (
   input  logic             clk,
   input  logic             rst,
   tx_framereader_if.master bus
);
   localparam int unsigned PH_W       = $clog2(SYM_PER);
   localparam int unsigned CNT_W      = 10;
   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned SMP_W      = 12;
   localparam int unsigned FRAME_SYMS = PRE_LEN + NSYM + GUARD_LEN;

   localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(SYM_PER - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(FRAME_SYMS - 1);
   localparam logic [CNT_W-1:0]  PAY_START   = CNT_W'(PRE_LEN);
   localparam logic [CNT_W-1:0]  GUARD_START = CNT_W'(PRE_LEN + NSYM);
   localparam logic [CNT_W-1:0]  NSYM_CNT    = CNT_W'(NSYM);
   localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(NSYM - 1);
   localparam logic [SMP_W-1:0]  AMP_POS     = SMP_W'(PRE_AMP);
   localparam logic [SMP_W-1:0]  AMP_NEG     = SMP_W'(-PRE_AMP);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRE,
      ST_PAY,
      ST_GUARD
   } state_e;

   state_e             state_q, state_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic [CNT_W-1:0]   symcnt_q, symcnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [SMP_W-1:0]   re_q, re_d;
   logic [SMP_W-1:0]   im_q, im_d;
   logic               busy_q, busy_d;
   logic               framedone_q, framedone_d;
   logic               err_q, err_d;
   logic               symouten_q, symouten_d;

   logic               wrap_c;
   logic               last_clk_c;
   logic               start_c;
   logic [CNT_W-1:0]   nxt_cnt_c;
   logic [CNT_W-1:0]   pay_next_c;

   // Next-state and output computation; a request on the final clock chains frames
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      symcnt_d    = symcnt_q;
      addr_d      = addr_q;
      re_d        = re_q;
      im_d        = im_q;
      busy_d      = busy_q;
      framedone_d = 1'b0;
      err_d       = 1'b0;
      symouten_d  = 1'b0;
      start_c     = 1'b0;

      wrap_c     = (phase_q == PH_LAST);
      last_clk_c = (state_q == ST_GUARD) && wrap_c && (symcnt_q == CNT_LAST);
      nxt_cnt_c  = symcnt_q + CNT_W'(1);
      // RAM address for the payload symbol after the one about to start
      pay_next_c = nxt_cnt_c - PAY_START + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            start_c = bus.framestart;
         end
         default: begin
            if (last_clk_c) begin
               state_d     = ST_IDLE;
               phase_d     = '0;
               symcnt_d    = '0;
               addr_d      = '0;
               re_d        = '0;
               im_d        = '0;
               busy_d      = 1'b0;
               framedone_d = 1'b1;
               start_c     = bus.framestart;
            end else begin
               err_d = bus.framestart;
               if (wrap_c) begin
                  phase_d    = '0;
                  symouten_d = 1'b1;
                  symcnt_d   = nxt_cnt_c;
                  if (nxt_cnt_c < PAY_START) begin
                     state_d = ST_PRE;
                     re_d    = nxt_cnt_c[0] ? AMP_NEG : AMP_POS;
                     im_d    = '0;
                  end else if (nxt_cnt_c < GUARD_START) begin
                     // RAM data has been stable since one clock after the address was set
                     state_d = ST_PAY;
                     re_d    = {bus.symin[15:8], 4'b0000};
                     im_d    = {bus.symin[7:0], 4'b0000};
                     addr_d  = (pay_next_c < NSYM_CNT) ? ADDR_W'(pay_next_c) : ADDR_LAST;
                  end else begin
                     state_d = ST_GUARD;
                     re_d    = '0;
                     im_d    = '0;
                     addr_d  = ADDR_LAST;
                  end
               end else begin
                  phase_d = phase_q + PH_W'(1);
               end
            end
         end
      endcase

      if (start_c) begin
         state_d    = ST_PRE;
         phase_d    = '0;
         symcnt_d   = '0;
         addr_d     = '0;
         re_d       = AMP_POS;
         im_d       = '0;
         busy_d     = 1'b1;
         symouten_d = 1'b1;
      end
   end

   // State and output registers, cleared immediately on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         symcnt_q    <= '0;
         addr_q      <= '0;
         re_q        <= '0;
         im_q        <= '0;
         busy_q      <= 1'b0;
         framedone_q <= 1'b0;
         err_q       <= 1'b0;
         symouten_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         symcnt_q    <= symcnt_d;
         addr_q      <= addr_d;
         re_q        <= re_d;
         im_q        <= im_d;
         busy_q      <= busy_d;
         framedone_q <= framedone_d;
         err_q       <= err_d;
         symouten_q  <= symouten_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.framedone  = framedone_q;
   assign bus.err        = err_q;
   assign bus.symin_addr = addr_q;
   assign bus.symouten   = symouten_q;
   assign bus.symout_re  = re_q;
   assign bus.symout_im  = im_q;
   assign bus.symcnt     = symcnt_q;
endmodule

// File: tb/tb_tx_framereader.sv
// Bench for tx_framereader: probe table on a default frame, scoreboarded symbol
// stream for two parameter sets, plus error, back-to-back and reset-abort sequences.
`timescale 1ns/1ps
module tb_tx_framereader;
   localparam int unsigned SP1  = 8;
   localparam int unsigned PL   = 32;
   localparam int unsigned NS1  = 128;
   localparam int unsigned GL   = 16;
   localparam int unsigned TOT1 = PL + NS1 + GL;
   localparam int unsigned SP2  = 2;
   localparam int unsigned NS2  = 4;
   localparam int unsigned TOT2 = PL + NS2 + GL;
   localparam int unsigned LEN1 = TOT1 * SP1;
   localparam int unsigned LEN2 = TOT2 * SP2;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;
   int          nchecks = 0;
   int          nerrs = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tx_framereader_if if1 ();
   tx_framereader_if if2 ();

   tx_framereader #(.SYM_PER(SP1), .PRE_LEN(PL), .PRE_AMP(1024), .NSYM(NS1), .GUARD_LEN(GL))
      u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   tx_framereader #(.SYM_PER(SP2), .PRE_LEN(PL), .PRE_AMP(1024), .NSYM(NS2), .GUARD_LEN(GL))
      u_dut2 (.clk(clk), .rst(rst), .bus(if2));

   // Symbol RAMs with one clock read latency
   logic [15:0] ram2 [NS2];
   always @(posedge clk) begin
      if1.symin <= {1'b0, if1.symin_addr, ~{1'b0, if1.symin_addr}};
      if2.symin <= ram2[if2.symin_addr[1:0]];
   end

   typedef struct packed {
      logic [9:0]  cnt;
      logic [11:0] re;
      logic [11:0] im;
   } sym_t;

   sym_t q1[$];
   sym_t q2[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic sym_t exp_sym(input bit which, input int unsigned k);
      sym_t        s;
      logic [7:0]  b;
      logic [15:0] w;
      int unsigned ns;
      ns    = which ? NS2 : NS1;
      s.cnt = 10'(k);
      s.re  = 12'h000;
      s.im  = 12'h000;
      if (k < PL) begin
         s.re = (k % 2 == 1) ? 12'hC00 : 12'h400;
      end else if (k < PL + ns) begin
         b    = 8'(k - PL);
         w    = which ? ram2[2'(k - PL)] : {b, ~b};
         s.re = {w[15:8], 4'h0};
         s.im = {w[7:0], 4'h0};
      end
      return s;
   endfunction

   function automatic void push_frame(input bit which);
      for (int k = 0; k < int'(which ? TOT2 : TOT1); k++) begin
         if (which) q2.push_back(exp_sym(1'b1, k));
         else       q1.push_back(exp_sym(1'b0, k));
      end
   endfunction

   // Scoreboard monitors: framedone frame length, symbol spacing and symbol content
   int unsigned seen1 = 0, last1 = 0, done1 = 0;
   int unsigned seen2 = 0, last2 = 0, done2 = 0;
   sym_t        a1, a2;

   always @(negedge clk) begin
      if (rst) begin
         if (if1.framedone) begin
            done1++;
            chk("frame1_symbols", 64'(seen1), 64'(TOT1));
         end
         if (if1.symouten) begin
            if (if1.symcnt != 10'd0) chk("sym1_spacing", 64'(cyc - last1), 64'(SP1));
            last1 = cyc;
            seen1 = (if1.symcnt == 10'd0) ? 1 : seen1 + 1;
            a1    = {if1.symcnt, if1.symout_re, if1.symout_im};
            if (q1.size() == 0) chk("sym1_expected_pending", 64'(q1.size() != 0), 64'(1));
            else                chk("sym1_data", 64'(a1), 64'(q1.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (if2.framedone) begin
            done2++;
            chk("frame2_symbols", 64'(seen2), 64'(TOT2));
         end
         if (if2.symouten) begin
            if (if2.symcnt != 10'd0) chk("sym2_spacing", 64'(cyc - last2), 64'(SP2));
            last2 = cyc;
            seen2 = (if2.symcnt == 10'd0) ? 1 : seen2 + 1;
            a2    = {if2.symcnt, if2.symout_re, if2.symout_im};
            if (q2.size() == 0) chk("sym2_expected_pending", 64'(q2.size() != 0), 64'(1));
            else                chk("sym2_data", 64'(a2), 64'(q2.pop_front()));
         end
      end
   end

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse framestart for one clock; returns at offset 0 of the new frame
   task automatic start_frame(input bit which);
      if (which) if2.framestart = 1'b1;
      else       if1.framestart = 1'b1;
      push_frame(which);
      step(1);
      if1.framestart = 1'b0;
      if2.framestart = 1'b0;
   endtask

   task automatic run_done(input bit which, input int unsigned exp_n);
      int unsigned n;
      bit          seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < exp_n + 16) begin
         step(1);
         n++;
         seen = which ? if2.framedone : if1.framedone;
      end
      chk(which ? "done2_latency" : "done1_latency", 64'(n), 64'(exp_n));
   endtask

   typedef struct {
      int unsigned off;
      logic        busy;
      logic        souten;
      logic        done;
      logic [9:0]  cnt;
      logic [11:0] re;
      logic [11:0] im;
      logic [6:0]  addr;
   } vec_t;

   localparam int NV = 13;
   vec_t vt [NV];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish, got t=%0t required < 1ms", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned now;
      int unsigned d0;
      int unsigned n;

      vt[0]  = '{0,    1'b1, 1'b1, 1'b0, 10'd0,   12'h400, 12'h000, 7'd0};
      vt[1]  = '{3,    1'b1, 1'b0, 1'b0, 10'd0,   12'h400, 12'h000, 7'd0};
      vt[2]  = '{8,    1'b1, 1'b1, 1'b0, 10'd1,   12'hC00, 12'h000, 7'd0};
      vt[3]  = '{16,   1'b1, 1'b1, 1'b0, 10'd2,   12'h400, 12'h000, 7'd0};
      vt[4]  = '{255,  1'b1, 1'b0, 1'b0, 10'd31,  12'hC00, 12'h000, 7'd0};
      vt[5]  = '{256,  1'b1, 1'b1, 1'b0, 10'd32,  12'h000, 12'hFF0, 7'd1};
      vt[6]  = '{288,  1'b1, 1'b1, 1'b0, 10'd36,  12'h040, 12'hFB0, 7'd5};
      vt[7]  = '{297,  1'b1, 1'b0, 1'b0, 10'd37,  12'h050, 12'hFA0, 7'd6};
      vt[8]  = '{1272, 1'b1, 1'b1, 1'b0, 10'd159, 12'h7F0, 12'h800, 7'd127};
      vt[9]  = '{1280, 1'b1, 1'b1, 1'b0, 10'd160, 12'h000, 12'h000, 7'd127};
      vt[10] = '{1407, 1'b1, 1'b0, 1'b0, 10'd175, 12'h000, 12'h000, 7'd127};
      vt[11] = '{1408, 1'b0, 1'b0, 1'b1, 10'd0,   12'h000, 12'h000, 7'd0};
      vt[12] = '{1409, 1'b0, 1'b0, 1'b0, 10'd0,   12'h000, 12'h000, 7'd0};

      for (int i = 0; i < int'(NS2); i++) ram2[i] = 16'($urandom);

      rst            = 1'b0;
      if1.framestart = 1'b0;
      if2.framestart = 1'b0;
      step(3);

      // Reset state
      chk("rst_busy",      64'(if1.busy),       64'(0));
      chk("rst_framedone", 64'(if1.framedone),  64'(0));
      chk("rst_err",       64'(if1.err),        64'(0));
      chk("rst_symouten",  64'(if1.symouten),   64'(0));
      chk("rst_re",        64'(if1.symout_re),  64'(0));
      chk("rst_im",        64'(if1.symout_im),  64'(0));
      chk("rst_symcnt",    64'(if1.symcnt),     64'(0));
      chk("rst_addr",      64'(if1.symin_addr), 64'(0));
      rst = 1'b1;
      step(6);

      // Default frame against the probe table
      start_frame(1'b0);
      now = 0;
      for (int i = 0; i < NV; i++) begin
         while (now < vt[i].off) begin
            step(1);
            now++;
         end
         chk("vec_busy",      64'(if1.busy),       64'(vt[i].busy));
         chk("vec_symouten",  64'(if1.symouten),   64'(vt[i].souten));
         chk("vec_framedone", 64'(if1.framedone),  64'(vt[i].done));
         chk("vec_symcnt",    64'(if1.symcnt),     64'(vt[i].cnt));
         chk("vec_re",        64'(if1.symout_re),  64'(vt[i].re));
         chk("vec_im",        64'(if1.symout_im),  64'(vt[i].im));
         chk("vec_addr",      64'(if1.symin_addr), 64'(vt[i].addr));
         chk("vec_err",       64'(if1.err),        64'(0));
      end
      step(4);

      // Request while busy: one err pulse, frame undisturbed
      d0 = done1;
      start_frame(1'b0);
      step(199);
      if1.framestart = 1'b1;
      step(1);
      if1.framestart = 1'b0;
      chk("err_pulse",      64'(if1.err),  64'(1));
      chk("err_busy",       64'(if1.busy), 64'(1));
      step(1);
      chk("err_pulse_end",  64'(if1.err),  64'(0));
      run_done(1'b0, LEN1 - 201);
      step(20);
      chk("err_one_done",   64'(done1 - d0), 64'(1));
      chk("err_idle_after", 64'(if1.busy),   64'(0));

      // Back-to-back: request on the final clock of a frame
      start_frame(1'b0);
      step(LEN1 - 1);
      if1.framestart = 1'b1;
      push_frame(1'b0);
      step(1);
      if1.framestart = 1'b0;
      chk("b2b_framedone", 64'(if1.framedone), 64'(1));
      chk("b2b_busy",      64'(if1.busy),      64'(1));
      chk("b2b_symouten",  64'(if1.symouten),  64'(1));
      chk("b2b_symcnt",    64'(if1.symcnt),    64'(0));
      chk("b2b_re",        64'(if1.symout_re), 64'(12'h400));
      chk("b2b_err",       64'(if1.err),       64'(0));
      run_done(1'b0, LEN1);
      chk("b2b_idle_after", 64'(if1.busy), 64'(0));
      step(4);

      // Reset during payload symbol 40
      start_frame(1'b0);
      n = 0;
      while (if1.symcnt != 10'd72 && n < LEN1) begin
         step(1);
         n++;
      end
      chk("abort_reach_pay40", 64'(if1.symcnt), 64'(72));
      step(3);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("abort_busy",     64'(if1.busy),       64'(0));
      chk("abort_symouten", 64'(if1.symouten),   64'(0));
      chk("abort_re",       64'(if1.symout_re),  64'(0));
      chk("abort_im",       64'(if1.symout_im),  64'(0));
      chk("abort_symcnt",   64'(if1.symcnt),     64'(0));
      chk("abort_addr",     64'(if1.symin_addr), 64'(0));
      q1.delete();
      d0 = done1;
      step(4);
      chk("abort_no_done_in_rst", 64'(if1.framedone), 64'(0));
      rst = 1'b1;
      step(3);
      chk("abort_no_done_after", 64'(if1.framedone), 64'(0));
      chk("abort_done_count",    64'(done1 - d0),    64'(0));
      start_frame(1'b0);
      chk("abort_restart_busy",  64'(if1.busy),      64'(1));
      run_done(1'b0, LEN1);
      step(4);

      // Short configuration: SYM_PER=2, NSYM=4, random RAM contents
      start_frame(1'b1);
      chk("p2_busy",     64'(if2.busy),      64'(1));
      chk("p2_symouten", 64'(if2.symouten),  64'(1));
      chk("p2_re",       64'(if2.symout_re), 64'(12'h400));
      run_done(1'b1, LEN2);
      chk("p2_idle_after", 64'(if2.busy), 64'(0));
      step(4);

      chk("q1_drained", 64'(q1.size()), 64'(0));
      chk("q2_drained", 64'(q2.size()), 64'(0));
      chk("p2_done_count", 64'(done2), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nerrs);
      $finish;
   end
endmodule
